// File: rtl/bambu_ext_mem_model_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bambu_ext_mem_model_pkg
// Brief    : Shared types, default latencies and lane helpers for the
//            external memory model.
// Revision : 1.0 - initial release
// ============================================================================
package bambu_ext_mem_model_pkg;

    localparam int c_DEF_RD_LAT = 2;
    localparam int c_DEF_WR_LAT = 1;

    typedef enum logic [1:0] {
        ACC_IDLE     = 2'd0,
        ACC_READ     = 2'd1,
        ACC_WRITE    = 2'd2,
        ACC_CONFLICT = 2'd3
    } acc_e;

    // Number of lane bits an access really touches.
    function automatic int eff_bits(input int size, input int data_w);
        return (size > data_w) ? data_w : size;
    endfunction

    // Bytes spanned by an access; a zero-size access still occupies one byte.
    function automatic int lane_bytes(input int bits);
        int nb;
        nb = (bits + 7) / 8;
        return (nb < 1) ? 1 : nb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bambu_ext_mem_model_if.sv
`default_nettype none
// ============================================================================
// Module   : bambu_ext_mem_model_if
// Brief    : Multi-channel master memory bus between an HLS top and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface bambu_ext_mem_model_if #(
    parameter int CH     = 2,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16,
    parameter int SIZE_W = 5
);
    logic [CH-1:0]        Mout_oe_ram;
    logic [CH-1:0]        Mout_we_ram;
    logic [CH*ADDR_W-1:0] Mout_addr_ram;
    logic [CH*DATA_W-1:0] Mout_Wdata_ram;
    logic [CH*SIZE_W-1:0] Mout_data_ram_size;
    logic [CH*DATA_W-1:0] M_Rdata_ram;
    logic [CH-1:0]        M_DataRdy;

    modport master (
        output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
        input  M_Rdata_ram, M_DataRdy
    );

    modport slave (
        input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
        output M_Rdata_ram, M_DataRdy
    );
endinterface
`default_nettype wire

// File: rtl/bambu_ext_mem_chan.sv
`default_nettype none
// ============================================================================
// Module   : bambu_ext_mem_chan
// Brief    : One channel: claim decode, latency counter, read delay line,
//            completion pulse and oe/we conflict detection.
// Revision : 1.0 - initial release
// ============================================================================
module bambu_ext_mem_chan
    import bambu_ext_mem_model_pkg::*;
#(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 16,
    parameter int SIZE_W    = 5,
    parameter int MEMSIZE   = 64,
    parameter int BASE_ADDR = 0,
    parameter int RD_LAT    = c_DEF_RD_LAT,
    parameter int WR_LAT    = c_DEF_WR_LAT
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_oe,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [SIZE_W-1:0] i_size,
    input  wire logic [DATA_W-1:0] i_rd_lane,
    output logic                   o_claimed,
    output int                     o_off,
    output int                     o_nbits,
    output logic [DATA_W-1:0]      o_rd_data,
    output logic                   o_data_rdy,
    output logic                   o_wr_commit,
    output logic                   o_conflict
);
    localparam int c_MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int c_CNT_W   = (c_MAX_LAT > 1) ? $clog2(c_MAX_LAT) : 1;

    acc_e               w_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_last;
    logic               w_busy;
    logic               w_done;
    logic [DATA_W-1:0]  w_rd_dly;
    int                 w_nb;

    always_comb begin
        o_off      = int'(i_addr) - BASE_ADDR;
        o_nbits    = eff_bits(int'(i_size), DATA_W);
        w_nb       = lane_bytes(o_nbits);
        o_claimed  = (o_off >= 0) && (o_off + w_nb <= MEMSIZE);
        o_conflict = i_oe & i_we;
        w_acc      = ACC_IDLE;
        if (o_conflict)
            w_acc = ACC_CONFLICT;
        else if (o_claimed && i_oe)
            w_acc = ACC_READ;
        else if (o_claimed && i_we)
            w_acc = ACC_WRITE;
        w_last      = (w_acc == ACC_READ) ? c_CNT_W'(RD_LAT - 1) : c_CNT_W'(WR_LAT - 1);
        w_busy      = (w_acc == ACC_READ) || (w_acc == ACC_WRITE);
        // Reset drops an in-flight access, so completion is masked while it is high.
        w_done      = !rst && w_busy && (r_cnt == w_last);
        o_data_rdy  = w_done;
        o_wr_commit = w_done && (w_acc == ACC_WRITE);
        o_rd_data   = (!rst && (w_acc == ACC_READ)) ? w_rd_dly : '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (!w_busy || w_done)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    generate
        if (RD_LAT == 1) begin : g_rd_direct
            assign w_rd_dly = i_rd_lane;
        end else begin : g_rd_pipe
            logic [DATA_W-1:0] r_stage [RD_LAT-1];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < RD_LAT - 1; i++)
                        r_stage[i] <= '0;
                end else begin
                    r_stage[0] <= i_rd_lane;
                    for (int i = 1; i < RD_LAT - 1; i++)
                        r_stage[i] <= r_stage[i-1];
                end
            end
            assign w_rd_dly = r_stage[RD_LAT-2];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/bambu_ext_mem_model.sv
`default_nettype none
// ============================================================================
// Module   : bambu_ext_mem_model
// Brief    : Off-chip byte memory slave for HLS master channels with per-channel
//            latency, masked little-endian writes, preload and conflict flag.
// Revision : 1.0 - initial release
// ============================================================================
module bambu_ext_mem_model
    import bambu_ext_mem_model_pkg::*;
#(
    parameter int CH        = 2,
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 16,
    parameter int SIZE_W    = 5,
    parameter int MEMSIZE   = 64,
    parameter int BASE_ADDR = 0,
    parameter int RD_LAT    = c_DEF_RD_LAT,
    parameter int WR_LAT    = c_DEF_WR_LAT
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              ld_en,
    input  wire logic [ADDR_W-1:0] ld_addr,
    input  wire logic [7:0]        ld_data,
    bambu_ext_mem_model_if.slave   bus,
    output logic                   err_conflict
);
    localparam int c_LANE_B = DATA_W / 8;
    localparam int c_IDX_W  = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;

    logic [7:0]        r_mem     [MEMSIZE];
    logic [7:0]        w_mem_nxt [MEMSIZE];
    logic [DATA_W-1:0] w_rd_lane [CH];
    logic [DATA_W-1:0] w_rd_data [CH];
    int                w_off     [CH];
    int                w_nbits   [CH];
    logic [CH-1:0]     w_claimed;
    logic [CH-1:0]     w_data_rdy;
    logic [CH-1:0]     w_wr_commit;
    logic [CH-1:0]     w_conflict;
    logic              r_err;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_chan
            bambu_ext_mem_chan #(
                .ADDR_W    (ADDR_W),
                .DATA_W    (DATA_W),
                .SIZE_W    (SIZE_W),
                .MEMSIZE   (MEMSIZE),
                .BASE_ADDR (BASE_ADDR),
                .RD_LAT    (RD_LAT),
                .WR_LAT    (WR_LAT)
            ) u_chan (
                .clk         (clock),
                .rst         (reset),
                .i_oe        (bus.Mout_oe_ram[gi]),
                .i_we        (bus.Mout_we_ram[gi]),
                .i_addr      (bus.Mout_addr_ram[gi*ADDR_W +: ADDR_W]),
                .i_size      (bus.Mout_data_ram_size[gi*SIZE_W +: SIZE_W]),
                .i_rd_lane   (w_rd_lane[gi]),
                .o_claimed   (w_claimed[gi]),
                .o_off       (w_off[gi]),
                .o_nbits     (w_nbits[gi]),
                .o_rd_data   (w_rd_data[gi]),
                .o_data_rdy  (w_data_rdy[gi]),
                .o_wr_commit (w_wr_commit[gi]),
                .o_conflict  (w_conflict[gi])
            );
            assign bus.M_Rdata_ram[gi*DATA_W +: DATA_W] = w_rd_data[gi];
        end
    endgenerate

    assign bus.M_DataRdy = w_data_rdy;
    assign err_conflict  = r_err;

    // Raw little-endian lane per channel, bits at or above the size cleared.
    always_comb begin
        int idx;
        idx = 0;
        for (int c = 0; c < CH; c++) begin
            w_rd_lane[c] = '0;
            if (w_claimed[c]) begin
                for (int k = 0; k < c_LANE_B; k++) begin
                    idx = w_off[c] + k;
                    if (idx < MEMSIZE)
                        w_rd_lane[c][k*8 +: 8] = r_mem[idx[c_IDX_W-1:0]];
                end
            end
            for (int i = 0; i < DATA_W; i++)
                if (i >= w_nbits[c])
                    w_rd_lane[c][i] = 1'b0;
        end
    end

    // Channels merge in ascending order so the highest index lands last; preload beats all.
    always_comb begin
        int idx;
        int ld_off;
        idx    = 0;
        ld_off = int'(ld_addr) - BASE_ADDR;
        for (int b = 0; b < MEMSIZE; b++)
            w_mem_nxt[b] = r_mem[b];
        for (int c = 0; c < CH; c++) begin
            if (w_wr_commit[c]) begin
                for (int i = 0; i < DATA_W; i++) begin
                    idx = w_off[c] + i / 8;
                    if ((i < w_nbits[c]) && (idx < MEMSIZE))
                        w_mem_nxt[idx[c_IDX_W-1:0]][i%8] = bus.Mout_Wdata_ram[c*DATA_W + i];
                end
            end
        end
        if (ld_en && (ld_off >= 0) && (ld_off < MEMSIZE))
            w_mem_nxt[ld_off[c_IDX_W-1:0]] = ld_data;
    end

    always_ff @(posedge clock) begin
        for (int b = 0; b < MEMSIZE; b++)
            r_mem[b] <= w_mem_nxt[b];
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_err <= 1'b0;
        else if (|w_conflict)
            r_err <= 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_bambu_ext_mem_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_bambu_ext_mem_model
// Brief    : Scoreboard bench for the external memory model with a byte-array
//            reference model and randomized channel traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bambu_ext_mem_model;
    localparam int CH = 2, ADDR_W = 7, DATA_W = 16, SIZE_W = 5;
    localparam int MEMSIZE = 64, RD_LAT = 2, WR_LAT = 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       ld_en;
    logic [6:0] ld_addr;
    logic [7:0] ld_data;
    logic       err_conflict;

    always #5 clock = ~clock;

    bambu_ext_mem_model_if #(.CH(CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W)) bus ();

    bambu_ext_mem_model #(
        .CH(CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W),
        .MEMSIZE(MEMSIZE), .BASE_ADDR(0), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
    ) dut (
        .clock(clock), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .bus(bus), .err_conflict(err_conflict)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  ref_mem [MEMSIZE];
    logic [16:0] exp_q0 [$];
    logic [16:0] exp_q1 [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain bit-by-bit little-endian byte array.
    function automatic int eff(input int size);
        return (size > DATA_W) ? DATA_W : size;
    endfunction

    function automatic bit fits(input int addr, input int size);
        int nb;
        nb = (eff(size) + 7) / 8;
        if (nb < 1) nb = 1;
        return (addr + nb <= MEMSIZE);
    endfunction

    function automatic logic [15:0] mread(input int addr, input int size);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < eff(size); i++)
            if (addr + i / 8 < MEMSIZE) v[i] = ref_mem[addr + i/8][i%8];
        return v;
    endfunction

    task automatic mwrite(input int addr, input int size, input logic [15:0] wd);
        for (int i = 0; i < eff(size); i++)
            ref_mem[addr + i/8][i%8] = wd[i];
    endtask

    task automatic push_exp(input int c, input logic [16:0] e);
        if (c == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // Monitor: every completion pulse must match the oldest expectation of its channel.
    always @(negedge clock) begin
        logic [16:0] e;
        bit          have;
        for (int c = 0; c < CH; c++) begin
            if (bus.M_DataRdy[c] === 1'b1) begin
                e    = '0;
                have = 1'b0;
                if (c == 0 && exp_q0.size() > 0) begin have = 1'b1; e = exp_q0.pop_front(); end
                if (c == 1 && exp_q1.size() > 0) begin have = 1'b1; e = exp_q1.pop_front(); end
                n_vec++;
                if (!have) begin
                    n_err++;
                    $display("FAIL unexpected_rdy ch%0d: got DataRdy=1 want 0", c);
                end else if (e[16] && (bus.M_Rdata_ram[c*16 +: 16] !== e[15:0])) begin
                    n_err++;
                    $display("FAIL rdata ch%0d: got 0x%0h want 0x%0h", c, bus.M_Rdata_ram[c*16 +: 16], e[15:0]);
                end
            end
        end
    end

    task automatic set_req(input int c, input bit oe, input bit we, input int addr,
                           input int size, input logic [15:0] wd);
        bus.Mout_oe_ram[c]                  = oe;
        bus.Mout_we_ram[c]                  = we;
        bus.Mout_addr_ram[c*ADDR_W +: ADDR_W] = addr[6:0];
        bus.Mout_data_ram_size[c*SIZE_W +: SIZE_W] = size[4:0];
        bus.Mout_Wdata_ram[c*DATA_W +: DATA_W] = wd;
    endtask

    // Issue one access at posedge+1, hold it until completion (or a bound), release it.
    task automatic access(input int c, input bit wr, input int addr, input int size,
                          input logic [15:0] wd, input bit exp_rdy, input logic [15:0] exp_rd,
                          input string name);
        int cyc;
        bit seen;
        set_req(c, !wr, wr, addr, size, wd);
        if (exp_rdy) push_exp(c, {!wr, exp_rd});
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < (exp_rdy ? 8 : 5)) begin
            @(negedge clock);
            cyc++;
            if (bus.M_DataRdy[c] === 1'b1) seen = 1'b1;
            else if (!exp_rdy && !wr) check({name, "_rdata0"}, bus.M_Rdata_ram[c*16 +: 16], 0);
        end
        if (exp_rdy) begin
            if (!seen) begin
                n_vec++;
                n_err++;
                $display("FAIL %s_timeout: got no DataRdy want DataRdy", name);
                if (c == 0) void'(exp_q0.pop_back()); else void'(exp_q1.pop_back());
            end else begin
                check({name, "_lat"}, cyc, wr ? WR_LAT : RD_LAT);
            end
        end else begin
            check({name, "_nordy"}, seen, 0);
        end
        @(posedge clock);
        #1;
        bus.Mout_oe_ram[c] = 1'b0;
        bus.Mout_we_ram[c] = 1'b0;
    endtask

    task automatic preload(input int a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = a[6:0];
        ld_data = d;
        if (a < MEMSIZE) ref_mem[a] = d;
        @(posedge clock);
        #1;
        ld_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  d;
        logic [15:0] wd;
        int          c, addr, size;
        bit          wr;

        reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        bus.Mout_oe_ram = '0; bus.Mout_we_ram = '0; bus.Mout_addr_ram = '0;
        bus.Mout_Wdata_ram = '0; bus.Mout_data_ram_size = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_rdy", bus.M_DataRdy, 0);
        check("rst_rdata", bus.M_Rdata_ram, 0);
        check("rst_err", err_conflict, 0);
        @(posedge clock);
        #1 reset = 1'b0;

        for (int a = 0; a < MEMSIZE; a++) begin
            d = (a < 8) ? 8'(8'h11 + a) : 8'($urandom);
            preload(a, d);
        end
        preload(100, 8'hEE);

        // Directed: basic read, partial write, same-byte priority, preload override.
        access(0, 0, 2, 16, 16'h0, 1, 16'h1413, "t1_read");
        access(1, 1, 4, 12, 16'hABCD, 1, 16'h0, "t2_write");
        mwrite(4, 12, 16'hABCD);
        access(0, 0, 4, 16, 16'h0, 1, 16'h1BCD, "t2_readback");

        set_req(0, 0, 1, 6, 8, 16'h00AA);
        set_req(1, 0, 1, 6, 8, 16'h00BB);
        push_exp(0, 17'h0); push_exp(1, 17'h0);
        @(negedge clock);
        check("t3_both_rdy", bus.M_DataRdy, 2'b11);
        @(posedge clock);
        #1 bus.Mout_we_ram = '0;
        mwrite(6, 8, 16'h00AA);
        mwrite(6, 8, 16'h00BB);
        access(0, 0, 6, 8, 16'h0, 1, 16'h00BB, "t3_readback");

        set_req(0, 0, 1, 20, 8, 16'h0055);
        push_exp(0, 17'h0);
        ld_en = 1'b1; ld_addr = 7'd20; ld_data = 8'h77;
        @(negedge clock);
        check("t3b_rdy", bus.M_DataRdy[0], 1);
        @(posedge clock);
        #1 bus.Mout_we_ram = '0;
        ld_en = 1'b0;
        ref_mem[20] = 8'h77;
        access(1, 0, 20, 8, 16'h0, 1, 16'h0077, "t3b_readback");

        access(0, 0, 63, 16, 16'h0, 0, 16'h0, "t4_unclaimed");

        set_req(1, 1, 1, 8, 16, 16'h1234);
        @(negedge clock);
        check("t5_err_early", err_conflict, 0);
        check("t5_nordy", bus.M_DataRdy[1], 0);
        @(posedge clock);
        #1 bus.Mout_oe_ram = '0;
        bus.Mout_we_ram = '0;
        @(negedge clock);
        check("t5_err_set", err_conflict, 1);
        @(posedge clock);
        #1;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 60; n++) begin
            c    = int'($urandom_range(0, 1));
            wr   = ($urandom_range(0, 2) == 0);
            addr = int'($urandom_range(0, 70));
            size = int'($urandom_range(0, 20));
            wd   = 16'($urandom);
            access(c, wr, addr, size, wd, fits(addr, size), wr ? 16'h0 : mread(addr, size), "rand");
            if (wr && fits(addr, size)) mwrite(addr, size, wd);
        end
        check("err_sticky", err_conflict, 1);

        // Reset during the first cycle of a read and of a write: both dropped.
        set_req(0, 1, 0, 0, 16, 16'h0);
        set_req(1, 0, 1, 10, 8, {8'h00, ~ref_mem[10]});
        reset = 1'b1;
        @(negedge clock);
        check("t6_rst_rdy", bus.M_DataRdy, 0);
        check("t6_rst_rdata", bus.M_Rdata_ram, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        bus.Mout_oe_ram = '0;
        bus.Mout_we_ram = '0;
        @(negedge clock);
        check("t6_err_clr", err_conflict, 0);
        @(posedge clock);
        #1;
        access(0, 0, 0, 16, 16'h0, 1, mread(0, 16), "t6_reissue");
        access(1, 0, 10, 8, 16'h0, 1, mread(10, 8), "t6_nowrite");

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("queues_drained", exp_q0.size() + exp_q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
